// File: rtl/core_pkg.sv
// Shared core definitions: memory-bus owner encoding and arbiter states.
package core_pkg;

  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  typedef enum logic {
    ARB_IDLE,
    ARB_HOLD
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of IF, LSU and memory-side req/gnt/rvalid bus signals.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic            if_req_i;
  logic [AW-1:0]   if_addr_i;
  logic            if_gnt_o;
  logic            if_rvalid_o;
  logic [DW-1:0]   if_rdata_o;

  logic            lsu_req_i;
  logic            lsu_we_i;
  logic [AW-1:0]   lsu_addr_i;
  logic [DW/8-1:0] lsu_be_i;
  logic [DW-1:0]   lsu_wdata_i;
  logic            lsu_gnt_o;
  logic            lsu_rvalid_o;
  logic [DW-1:0]   lsu_rdata_o;

  logic            mem_req_o;
  logic            mem_we_o;
  logic [AW-1:0]   mem_addr_o;
  logic [DW/8-1:0] mem_be_o;
  logic [DW-1:0]   mem_wdata_o;
  logic            mem_gnt_i;
  logic            mem_rvalid_i;
  logic [DW-1:0]   mem_rdata_i;

  logic            err_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
    input  lsu_req_i, lsu_we_i, lsu_addr_i,
    input  lsu_be_i, lsu_wdata_i,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o,
    output mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output err_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
    output lsu_req_i, lsu_we_i, lsu_addr_i,
    output lsu_be_i, lsu_wdata_i,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o,
    input  mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  err_o
  );

endinterface

// File: rtl/owner_fifo.sv
// In-order FIFO of 1-bit owner tags for outstanding memory transactions.
module owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic din_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output logic head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din_i;
      wr_d        = nxt(wr_q);
    end
    if (do_pop) begin
      rd_d = nxt(rd_q);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// IF/LSU to single memory port arbiter with LSU priority,
// anti-starvation for IF, and in-order response routing.
module mem_arbiter
  import core_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int OUTSTANDING = 2,
  parameter int STARVE_MAX  = 4
) (
  input logic          clk_i,
  input logic          rst_ni,
  mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int BW = DW / 8;

  arb_state_e    state_q, state_d;
  logic          hold_sel_q, hold_sel_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          err_q, err_d;

  logic          sel;
  logic          req;
  logic          gnt;
  logic          if_gnt, lsu_gnt;
  logic          pop;
  logic          fifo_full, fifo_empty, fifo_head;
  logic          if_rv, lsu_rv;
  logic [AW-1:0] addr_sel;
  logic [BW-1:0] be_sel;
  logic [DW-1:0] wdata_sel;

  always_comb begin
    if (state_q == ARB_HOLD) begin
      sel = hold_sel_q;
    end else if (bus.if_req_i && bus.lsu_req_i) begin
      sel = (starve_q == SW'(STARVE_MAX)) ? OWN_IF : OWN_LSU;
    end else if (bus.lsu_req_i) begin
      sel = OWN_LSU;
    end else begin
      sel = OWN_IF;
    end
  end

  // Reset also masks the request so nothing leaks out while held in reset.
  assign req = rst_ni & (bus.if_req_i | bus.lsu_req_i) & ~fifo_full;
  assign gnt = req & bus.mem_gnt_i;

  assign if_gnt  = gnt & (sel == OWN_IF);
  assign lsu_gnt = gnt & (sel == OWN_LSU);

  always_comb begin
    addr_sel  = '0;
    be_sel    = '0;
    wdata_sel = '0;
    if (req) begin
      if (sel == OWN_LSU) begin
        addr_sel  = bus.lsu_addr_i;
        be_sel    = bus.lsu_be_i;
        wdata_sel = bus.lsu_wdata_i;
      end else begin
        addr_sel  = bus.if_addr_i;
        be_sel    = '1;
      end
    end
  end

  assign bus.mem_req_o   = req;
  assign bus.mem_we_o    = req & (sel == OWN_LSU) & bus.lsu_we_i;
  assign bus.mem_addr_o  = addr_sel;
  assign bus.mem_be_o    = be_sel;
  assign bus.mem_wdata_o = wdata_sel;

  assign bus.if_gnt_o  = if_gnt;
  assign bus.lsu_gnt_o = lsu_gnt;

  assign pop    = bus.mem_rvalid_i & ~fifo_empty;
  assign if_rv  = pop & (fifo_head == OWN_IF);
  assign lsu_rv = pop & (fifo_head == OWN_LSU);

  assign bus.if_rvalid_o  = if_rv;
  assign bus.lsu_rvalid_o = lsu_rv;
  assign bus.if_rdata_o   = if_rv ? bus.mem_rdata_i : '0;
  assign bus.lsu_rdata_o  = lsu_rv ? bus.mem_rdata_i : '0;

  assign bus.err_o = err_q;

  owner_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_owner_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (gnt),
    .din_i   (sel),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head)
  );

  always_comb begin
    state_d    = state_q;
    hold_sel_d = hold_sel_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (req && !bus.mem_gnt_i) begin
          state_d    = ARB_HOLD;
          hold_sel_d = sel;
        end
      end
      ARB_HOLD: begin
        if (bus.mem_gnt_i) begin
          state_d = ARB_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (if_gnt || !bus.if_req_i) begin
      starve_d = '0;
    end else if (lsu_gnt && starve_q != SW'(STARVE_MAX)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  assign err_d = err_q | (bus.mem_rvalid_i & fifo_empty);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      hold_sel_q <= OWN_IF;
      starve_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_sel_q <= hold_sel_d;
      starve_q   <= starve_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a queue-based model.
module tb_mem_arbiter;
  import core_pkg::*;

  localparam int OUTN = 2;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(
    .AW          (32),
    .DW          (32),
    .OUTSTANDING (OUTN),
    .STARVE_MAX  (SMAX)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  int checks = 0;
  int failures = 0;

  bit oq[$];
  bit held_v;
  bit held;
  int starve;
  bit err_m;
  bit last_if_gnt;
  bit last_lsu_gnt;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_step();
    bit ir, lr, own, ereq, eg, erv, eown;
    ir = bus.if_req_i;
    lr = bus.lsu_req_i;
    if (held_v) own = held;
    else if (ir && lr) own = (starve == SMAX) ? OWN_IF : OWN_LSU;
    else own = lr ? OWN_LSU : OWN_IF;
    ereq = rst_n && (ir || lr) && (oq.size() < OUTN);
    eg   = ereq && bus.mem_gnt_i;
    erv  = rst_n && bus.mem_rvalid_i && (oq.size() > 0);
    eown = (oq.size() > 0) ? oq[0] : 1'b0;

    chk("mem_req", bus.mem_req_o, ereq);
    chk("if_gnt", bus.if_gnt_o, eg && own == OWN_IF);
    chk("lsu_gnt", bus.lsu_gnt_o, eg && own == OWN_LSU);
    if (ereq) begin
      if (own == OWN_LSU) begin
        chk("addr_lsu", bus.mem_addr_o, bus.lsu_addr_i);
        chk("we_lsu", bus.mem_we_o, bus.lsu_we_i);
        chk("be_lsu", bus.mem_be_o, bus.lsu_be_i);
        chk("wdata_lsu", bus.mem_wdata_o, bus.lsu_wdata_i);
      end else begin
        chk("addr_if", bus.mem_addr_o, bus.if_addr_i);
        chk("we_if", bus.mem_we_o, 0);
        chk("be_if", bus.mem_be_o, 4'hF);
      end
    end
    chk("if_rvalid", bus.if_rvalid_o, erv && eown == OWN_IF);
    chk("lsu_rvalid", bus.lsu_rvalid_o, erv && eown == OWN_LSU);
    if (erv && eown == OWN_IF) chk("if_rdata", bus.if_rdata_o, bus.mem_rdata_i);
    if (erv && eown == OWN_LSU) chk("lsu_rdata", bus.lsu_rdata_o, bus.mem_rdata_i);
    chk("err", bus.err_o, err_m);

    last_if_gnt  = eg && own == OWN_IF;
    last_lsu_gnt = eg && own == OWN_LSU;

    if (!rst_n) begin
      oq.delete();
      held_v = 0;
      held   = OWN_IF;
      starve = 0;
      err_m  = 0;
    end else begin
      if (bus.mem_rvalid_i) begin
        if (oq.size() > 0) void'(oq.pop_front());
        else err_m = 1;
      end
      if (eg) begin
        oq.push_back(own);
        held_v = 0;
      end else if (ereq) begin
        held_v = 1;
        held   = own;
      end
      if (last_if_gnt || !ir) starve = 0;
      else if (last_lsu_gnt && starve < SMAX) starve++;
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  task automatic idle_inputs();
    bus.if_req_i     = 0;
    bus.if_addr_i    = '0;
    bus.lsu_req_i    = 0;
    bus.lsu_we_i     = 0;
    bus.lsu_addr_i   = '0;
    bus.lsu_be_i     = '0;
    bus.lsu_wdata_i  = '0;
    bus.mem_gnt_i    = 0;
    bus.mem_rvalid_i = 0;
    bus.mem_rdata_i  = '0;
  endtask

  task automatic drain();
    bus.if_req_i  = 0;
    bus.lsu_req_i = 0;
    bus.mem_gnt_i = 0;
    for (int k = 0; k < 8 && oq.size() > 0; k++) begin
      bus.mem_rvalid_i = 1;
      bus.mem_rdata_i  = $urandom;
      tick();
    end
    bus.mem_rvalid_i = 0;
  endtask

  logic [9:0] win;

  initial begin
    idle_inputs();
    held = OWN_IF;

    // reset state
    settle();
    chk("rst_mem_req", bus.mem_req_o, 0);
    chk("rst_gnts", {bus.if_gnt_o, bus.lsu_gnt_o}, 0);
    chk("rst_rvalids", {bus.if_rvalid_o, bus.lsu_rvalid_o}, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_addr", bus.mem_addr_o, 0);
    adv();
    rst_n = 1;
    tick();

    // single requester
    bus.if_req_i  = 1;
    bus.if_addr_i = 32'h100;
    bus.mem_gnt_i = 1;
    settle();
    chk("single_if_gnt", bus.if_gnt_o, 1);
    chk("single_addr", bus.mem_addr_o, 32'h100);
    adv();
    bus.if_req_i     = 0;
    bus.mem_gnt_i    = 0;
    bus.mem_rvalid_i = 1;
    bus.mem_rdata_i  = 32'hC000_1073;
    settle();
    chk("single_if_rvalid", bus.if_rvalid_o, 1);
    chk("single_if_rdata", bus.if_rdata_o, 32'hC000_1073);
    chk("single_lsu_rvalid", bus.lsu_rvalid_o, 0);
    adv();
    bus.mem_rvalid_i = 0;

    // contention
    for (int i = 0; i < 10; i++) begin
      bus.if_req_i     = 1;
      bus.if_addr_i    = 32'h104;
      bus.lsu_req_i    = 1;
      bus.lsu_we_i     = 1;
      bus.lsu_addr_i   = 32'h200;
      bus.lsu_be_i     = 4'hF;
      bus.lsu_wdata_i  = $urandom;
      bus.mem_gnt_i    = 1;
      bus.mem_rvalid_i = (oq.size() > 0);
      bus.mem_rdata_i  = $urandom;
      settle();
      win[i] = bus.lsu_gnt_o;
      adv();
    end
    chk("contention_pattern", win, 10'b01111_01111);
    drain();

    // stall hold
    bus.lsu_req_i  = 1;
    bus.lsu_we_i   = 0;
    bus.lsu_addr_i = 32'h300;
    bus.lsu_be_i   = 4'h3;
    bus.mem_gnt_i  = 0;
    settle();
    chk("stall_addr0", bus.mem_addr_o, 32'h300);
    adv();
    bus.if_req_i  = 1;
    bus.if_addr_i = 32'h400;
    for (int i = 1; i < 4; i++) begin
      bus.mem_gnt_i = (i == 3);
      settle();
      chk("stall_addr", bus.mem_addr_o, 32'h300);
      if (i == 3) chk("stall_lsu_first", bus.lsu_gnt_o, 1);
      adv();
    end
    bus.lsu_req_i = 0;
    bus.mem_gnt_i = 1;
    settle();
    chk("stall_if_next", bus.if_gnt_o, 1);
    adv();
    drain();

    // full FIFO
    bus.if_req_i   = 1;
    bus.if_addr_i  = 32'h10;
    bus.lsu_req_i  = 1;
    bus.lsu_we_i   = 0;
    bus.lsu_addr_i = 32'h20;
    bus.mem_gnt_i  = 1;
    settle();
    chk("full_g1_lsu", bus.lsu_gnt_o, 1);
    adv();
    bus.lsu_req_i = 0;
    settle();
    chk("full_g2_if", bus.if_gnt_o, 1);
    adv();
    settle();
    chk("full_req_low", bus.mem_req_o, 0);
    adv();
    bus.mem_rvalid_i = 1;
    bus.mem_rdata_i  = 32'h1111_1111;
    settle();
    chk("full_req_low_pop", bus.mem_req_o, 0);
    chk("full_rsp1_lsu", bus.lsu_rvalid_o, 1);
    chk("full_rsp1_data", bus.lsu_rdata_o, 32'h1111_1111);
    adv();
    bus.mem_rvalid_i = 0;
    settle();
    chk("full_req_resume", bus.mem_req_o, 1);
    adv();
    bus.if_req_i     = 0;
    bus.mem_gnt_i    = 0;
    bus.mem_rvalid_i = 1;
    bus.mem_rdata_i  = 32'h2222_2222;
    settle();
    chk("full_rsp2_if", bus.if_rvalid_o, 1);
    chk("full_rsp2_data", bus.if_rdata_o, 32'h2222_2222);
    adv();
    drain();

    // reset mid-operation
    bus.if_req_i  = 1;
    bus.if_addr_i = 32'h30;
    bus.mem_gnt_i = 1;
    tick();
    tick();
    rst_n = 0;
    #1;
    chk("rstmid_req", bus.mem_req_o, 0);
    chk("rstmid_gnt", bus.if_gnt_o, 0);
    chk("rstmid_addr", bus.mem_addr_o, 0);
    tick();
    tick();
    rst_n = 1;
    bus.if_addr_i = 32'h500;
    settle();
    chk("rstmid_fresh_gnt", bus.if_gnt_o, 1);
    adv();
    bus.if_req_i     = 0;
    bus.mem_gnt_i    = 0;
    bus.mem_rvalid_i = 1;
    bus.mem_rdata_i  = 32'h5A5A_5A5A;
    settle();
    chk("rstmid_fresh_rv", bus.if_rvalid_o, 1);
    chk("rstmid_fresh_data", bus.if_rdata_o, 32'h5A5A_5A5A);
    chk("rstmid_err", bus.err_o, 0);
    adv();
    bus.mem_rvalid_i = 0;

    // randomized traffic
    last_if_gnt  = 0;
    last_lsu_gnt = 0;
    for (int c = 0; c < 1500; c++) begin
      if (!bus.if_req_i || last_if_gnt) begin
        bus.if_req_i  = ($urandom_range(2) != 0);
        bus.if_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (!bus.lsu_req_i || last_lsu_gnt) begin
        bus.lsu_req_i   = ($urandom_range(2) != 0);
        bus.lsu_we_i    = $urandom_range(1);
        bus.lsu_addr_i  = $urandom;
        bus.lsu_be_i    = $urandom_range(15);
        bus.lsu_wdata_i = $urandom;
      end
      bus.mem_gnt_i    = ($urandom_range(3) != 0);
      bus.mem_rvalid_i = (oq.size() > 0) && ($urandom_range(2) != 0);
      bus.mem_rdata_i  = $urandom;
      tick();
    end
    drain();

    // spurious rvalid
    bus.mem_rvalid_i = 1;
    bus.mem_rdata_i  = 32'hDEAD_BEEF;
    settle();
    chk("spur_if_rv", bus.if_rvalid_o, 0);
    chk("spur_lsu_rv", bus.lsu_rvalid_o, 0);
    adv();
    bus.mem_rvalid_i = 0;
    settle();
    chk("spur_err_set", bus.err_o, 1);
    adv();
    repeat (3) tick();
    settle();
    chk("spur_err_sticky", bus.err_o, 1);
    adv();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
